// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle datapath and its controller.
// The datapath side (master) supplies Opcode/Zero; the controller side
// (slave) drives all enables, mux selects, ALU operation and status.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       IorD;
    logic       ALUSrcA;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUOP;
    logic [3:0] State;
    logic       Illegal;

    modport master (
        output Opcode, Zero,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
        input  IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOP,
        input  State, Illegal
    );

    modport slave (
        input  Opcode, Zero,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
        output IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOP,
        output State, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Optional feature: define MULTICYCLE_CONTROL_JUMP_EN to support the j
// instruction (JUMP state); without it opcode 000010 decodes as illegal.
// Outputs are registered from the next state, except PCWrite in BRANCH
// (follows Zero) and Illegal (follows Opcode in DECODE).
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

`ifdef MULTICYCLE_CONTROL_JUMP_EN
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,  S_RWB    = 4'd7,  S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,  S_RWB    = 4'd7,  S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,  S_IWB    = 4'd10
    } state_t;
`endif

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opcode;
    logic [5:0] w_next_opcode;
    logic       r_run;
    logic       w_illegal;

    logic       r_pcwrite, r_irwrite, r_memread, r_memwrite, r_regwrite;
    logic       r_iord, r_alusrca, r_regdst, r_memtoreg;
    logic [1:0] r_alusrcb, r_pcsrc;
    logic [2:0] r_aluop;

    // ALU operation for the immediate-ALU instructions
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_SLTI: return 3'b001;
            OP_ANDI: return 3'b010;
            OP_ORI:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Next-state and opcode-latch decision; r_run holds FETCH for one
    // extra edge after reset so FETCH enables appear before DECODE
    always_comb begin
        w_next_state  = S_FETCH;
        w_next_opcode = r_opcode;
        w_illegal     = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH:  w_next_state = S_DECODE;
                S_DECODE: begin
                    w_next_opcode = bus.Opcode;
                    case (bus.Opcode)
                        OP_LW, OP_SW: w_next_state = S_MEMADR;
                        OP_RTYPE:     w_next_state = S_REXEC;
                        OP_BEQ:       w_next_state = S_BRANCH;
                        OP_ADDI, OP_SLTI,
                        OP_ANDI, OP_ORI: w_next_state = S_IEXEC;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                        OP_J:         w_next_state = S_JUMP;
`endif
                        default: begin
                            w_next_state = S_FETCH;
                            w_illegal    = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: w_next_state = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  w_next_state = S_MEMWB;
                S_REXEC:  w_next_state = S_RWB;
                S_IEXEC:  w_next_state = S_IWB;
                default:  w_next_state = S_FETCH;
            endcase
        end
    end

    // State, opcode latch and registered outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_opcode   <= 6'd0;
            r_run      <= 1'b0;
            r_pcwrite  <= 1'b0;
            r_irwrite  <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_iord     <= 1'b0;
            r_alusrca  <= 1'b0;
            r_regdst   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrcb  <= 2'b01;
            r_pcsrc    <= 2'b00;
            r_aluop    <= 3'b000;
        end else begin
            r_run      <= 1'b1;
            r_state    <= w_next_state;
            r_opcode   <= w_next_opcode;
            r_pcwrite  <= 1'b0;
            r_irwrite  <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_iord     <= 1'b0;
            r_alusrca  <= 1'b0;
            r_regdst   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrcb  <= 2'b00;
            r_pcsrc    <= 2'b00;
            r_aluop    <= 3'b000;
            case (w_next_state)
                S_FETCH: begin
                    r_memread <= 1'b1;
                    r_irwrite <= 1'b1;
                    r_pcwrite <= 1'b1;
                    r_alusrcb <= 2'b01;
                end
                S_DECODE: r_alusrcb <= 2'b11;
                S_MEMADR: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                S_MEMRD: begin
                    r_memread <= 1'b1;
                    r_iord    <= 1'b1;
                end
                S_MEMWB: begin
                    r_regwrite <= 1'b1;
                    r_memtoreg <= 1'b1;
                end
                S_MEMWR: begin
                    r_memwrite <= 1'b1;
                    r_iord     <= 1'b1;
                end
                S_REXEC: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= 3'b100;
                end
                S_RWB: begin
                    r_regwrite <= 1'b1;
                    r_regdst   <= 1'b1;
                end
                S_BRANCH: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= 3'b101;
                    r_pcsrc   <= 2'b01;
                end
                S_IEXEC, S_IWB: begin
                    r_alusrca  <= 1'b1;
                    r_alusrcb  <= 2'b10;
                    r_aluop    <= imm_aluop(w_next_opcode);
                    r_regwrite <= (w_next_state == S_IWB);
                end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                S_JUMP: begin
                    r_pcsrc   <= 2'b10;
                    r_pcwrite <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Conditional PC write in BRANCH tracks Zero within the cycle
    assign bus.PCWrite  = r_pcwrite | ((r_state == S_BRANCH) & bus.Zero);
    assign bus.IRWrite  = r_irwrite;
    assign bus.MemRead  = r_memread;
    assign bus.MemWrite = r_memwrite;
    assign bus.RegWrite = r_regwrite;
    assign bus.IorD     = r_iord;
    assign bus.ALUSrcA  = r_alusrca;
    assign bus.RegDst   = r_regdst;
    assign bus.MemtoReg = r_memtoreg;
    assign bus.ALUSrcB  = r_alusrcb;
    assign bus.PCSrc    = r_pcsrc;
    assign bus.ALUOP    = r_aluop;
    assign bus.State    = r_state;
    assign bus.Illegal  = w_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions with spec cycle
// counts, hand sequences for reset corners, and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite, irwrite, memread, memwrite, regwrite;
        logic       iord, alusrca, regdst, memtoreg;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         cycles;
        logic       illegal;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    function automatic obs_t sample_dut();
        obs_t o;
        o.state    = bus.State;
        o.pcwrite  = bus.PCWrite;
        o.irwrite  = bus.IRWrite;
        o.memread  = bus.MemRead;
        o.memwrite = bus.MemWrite;
        o.regwrite = bus.RegWrite;
        o.iord     = bus.IorD;
        o.alusrca  = bus.ALUSrcA;
        o.regdst   = bus.RegDst;
        o.memtoreg = bus.MemtoReg;
        o.alusrcb  = bus.ALUSrcB;
        o.pcsrc    = bus.PCSrc;
        o.aluop    = bus.ALUOP;
        o.illegal  = bus.Illegal;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got state=%0d bits=%h, required state=%0d bits=%h",
                      name, got.state, got, exp.state, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic logic jump_en();
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_imm(input logic [5:0] op);
        return op == 6'b001000 || op == 6'b001010 || op == 6'b001100 || op == 6'b001101;
    endfunction

    function automatic bit supported(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || is_imm(op) || (op == 6'b000010 && jump_en());
    endfunction

    // Number of cycles FETCH to FETCH
    function automatic int model_len(input logic [5:0] op);
        if (op == 6'b100011) return 5;
        if (op == 6'b101011 || op == 6'b000000 || is_imm(op)) return 4;
        if (op == 6'b000100 || (op == 6'b000010 && jump_en())) return 3;
        return 2;
    endfunction

    // State visited in cycle k of an instruction (k=0 is FETCH)
    function automatic logic [3:0] model_state(input logic [5:0] op, input int k);
        if (k == 0 || k >= model_len(op)) return 4'd0;
        if (k == 1) return 4'd1;
        if (op == 6'b100011) return (k == 2) ? 4'd2 : (k == 3) ? 4'd3 : 4'd4;
        if (op == 6'b101011) return (k == 2) ? 4'd2 : 4'd5;
        if (op == 6'b000000) return (k == 2) ? 4'd6 : 4'd7;
        if (is_imm(op))      return (k == 2) ? 4'd9 : 4'd10;
        if (op == 6'b000100) return 4'd8;
        return 4'd11;
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] op);
        case (op)
            6'b001010: return 3'b001;
            6'b001100: return 3'b010;
            6'b001101: return 3'b011;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic obs_t model_out(input logic [3:0] st, input logic [5:0] op, input logic z);
        obs_t e;
        e = '0;
        e.state = st;
        case (st)
            4'd0: begin e.pcwrite = 1; e.irwrite = 1; e.memread = 1; e.alusrcb = 2'b01; end
            4'd1: begin e.alusrcb = 2'b11; e.illegal = !supported(op); end
            4'd2: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd3: begin e.memread = 1; e.iord = 1; end
            4'd4: begin e.regwrite = 1; e.memtoreg = 1; end
            4'd5: begin e.memwrite = 1; e.iord = 1; end
            4'd6: begin e.alusrca = 1; e.aluop = 3'b100; end
            4'd7: begin e.regwrite = 1; e.regdst = 1; end
            4'd8: begin e.alusrca = 1; e.aluop = 3'b101; e.pcsrc = 2'b01; e.pcwrite = z; end
            4'd9, 4'd10: begin
                e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = imm_op(op);
                e.regwrite = (st == 4'd10);
            end
            4'd11: begin e.pcsrc = 2'b10; e.pcwrite = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t reset_obs();
        obs_t e;
        e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    // Runs one instruction starting #1 after the edge entering FETCH;
    // Opcode is valid only in DECODE and random elsewhere
    task automatic run_instr(input logic [5:0] op, input logic z,
                             output int got_cycles, output logic saw_illegal);
        int   k;
        obs_t o;
        k = 0;
        saw_illegal = 1'b0;
        while (k < 8) begin
            bus.Opcode = (k == 1) ? op : 6'($urandom);
            bus.Zero   = (model_state(op, k) == 4'd8) ? z : 1'($urandom);
            @(negedge clk);
            o = sample_dut();
            if (o.illegal) saw_illegal = 1'b1;
            check_obs($sformatf("op%b_z%0d_cyc%0d", op, z, k), o,
                      model_out(model_state(op, k), op, z));
            @(posedge clk);
            #1;
            k++;
            if (bus.State == 4'd0) break;
        end
        got_cycles = k;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[12];
        logic [5:0] pool[9];
        int         cyc;
        logic       ill;
        logic [5:0] op;
        logic       z;

        tbl[0]  = '{6'b100011, 1'b0, 5, 1'b0};   // lw
        tbl[1]  = '{6'b101011, 1'b0, 4, 1'b0};   // sw
        tbl[2]  = '{6'b000000, 1'b0, 4, 1'b0};   // R-type
        tbl[3]  = '{6'b001000, 1'b0, 4, 1'b0};   // addi
        tbl[4]  = '{6'b001010, 1'b0, 4, 1'b0};   // slti
        tbl[5]  = '{6'b001100, 1'b0, 4, 1'b0};   // andi
        tbl[6]  = '{6'b001101, 1'b0, 4, 1'b0};   // ori
        tbl[7]  = '{6'b000100, 1'b1, 3, 1'b0};   // beq taken
        tbl[8]  = '{6'b000100, 1'b0, 3, 1'b0};   // beq not taken
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        tbl[9]  = '{6'b000010, 1'b0, 3, 1'b0};   // j
`else
        tbl[9]  = '{6'b000010, 1'b0, 2, 1'b1};   // j unsupported
`endif
        tbl[10] = '{6'b111111, 1'b0, 2, 1'b1};   // illegal
        tbl[11] = '{6'b000001, 1'b0, 2, 1'b1};   // illegal

        pool[0] = 6'b100011; pool[1] = 6'b101011; pool[2] = 6'b000000;
        pool[3] = 6'b001000; pool[4] = 6'b001010; pool[5] = 6'b001100;
        pool[6] = 6'b001101; pool[7] = 6'b000100; pool[8] = 6'b000010;

        // Reset values and release timing
        reset      = 1'b1;
        bus.Opcode = 6'b000000;
        bus.Zero   = 1'b1;
        repeat (2) @(negedge clk);
        check_obs("reset_values", sample_dut(), reset_obs());
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_obs("first_fetch_after_reset", sample_dut(), model_out(4'd0, 6'd0, 1'b0));

        // Table of instructions with fixed cycle counts
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].zero, cyc, ill);
            check_int($sformatf("cycles_op%b", tbl[i].op), cyc, tbl[i].cycles);
            check_int($sformatf("illegal_op%b", tbl[i].op), int'(ill), int'(tbl[i].illegal));
        end

        // Reset between edges while in MEMWR
        bus.Opcode = 6'b000000;
        @(posedge clk); #1;
        bus.Opcode = 6'b101011;
        @(posedge clk); #1;
        bus.Opcode = 6'b100011;
        @(posedge clk); #1;
        check_int("memwr_state", int'(bus.State), 5);
        check_int("memwr_enable", int'(bus.MemWrite), 1);
        #2;
        reset = 1'b1;
        #1;
        check_obs("async_reset_in_memwr", sample_dut(), reset_obs());
        @(posedge clk); #1;
        check_obs("reset_held_over_edge", sample_dut(), reset_obs());
        @(negedge clk);
        reset = 1'b0;
        bus.Opcode = 6'b111111;
        @(posedge clk); #1;
        check_obs("fetch_after_midop_reset", sample_dut(), model_out(4'd0, 6'd0, 1'b0));
        @(posedge clk); #1;
        check_obs("decode_after_midop_reset", sample_dut(), model_out(4'd1, 6'b111111, 1'b0));
        @(posedge clk); #1;
        check_int("illegal_returns_fetch", int'(bus.State), 0);

        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = pool[$urandom_range(0, 8)];
            z = 1'($urandom);
            run_instr(op, z, cyc, ill);
            check_int($sformatf("rand%0d_cycles_op%b", i, op), cyc, model_len(op));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
